// File: rtl/conv_pkg.sv
// Shared helpers for the KxK convolution filter: width helpers, wide
// arithmetic types and the final round-half-up / saturate function.
package conv_pkg;

  // Width of the generic arithmetic used by round_sat; wide enough for any
  // accumulator this filter is expected to produce.
  localparam int MAX_W = 64;

  typedef logic signed [15:0]      data_t;
  typedef logic signed [MAX_W-1:0] wide_t;

  // sat is the MSB so a concatenation {sat, upper, lower} unpacks it.
  typedef struct packed {
    logic  sat;
    wide_t value;
  } rs_t;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

  // Number of nodes at adder-tree level lvl for a given leaf count.
  function automatic int tree_cnt(input int leaves, input int lvl);
    return (leaves + (32'sd1 << lvl) - 32'sd1) >> lvl;
  endfunction

  // Round half-up at frac_w bits, then clamp to a signed data_w range.
  function automatic rs_t round_sat(input wide_t acc, input int data_w, input int frac_w);
    rs_t   r;
    wide_t rnd;
    wide_t max_v;
    wide_t min_v;
    rnd   = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    if (rnd > max_v) begin
      r.value = max_v;
      r.sat   = 1'b1;
    end else if (rnd < min_v) begin
      r.value = min_v;
      r.sat   = 1'b1;
    end else begin
      r.value = rnd;
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered binary adder tree: one register level per tree level, all
// levels advance together on en, an odd node passes through a register.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter  int LEAVES = 10,
  parameter  int W      = 36,
  localparam int LV     = clog2(LEAVES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [LEAVES*W-1:0] leaves,
  output logic                out_valid,
  output logic signed [W-1:0] sum
);

  genvar l, j;
  for (l = 0; l <= LV; l++) begin : g_lvl
    logic signed [W-1:0] node [0:LEAVES-1];
    logic                vld;

    if (l == 0) begin : g_leaf
      for (j = 0; j < LEAVES; j++) begin : g_in
        assign node[j] = leaves[j*W +: W];
      end
      assign vld = in_valid;
    end else begin : g_reg
      localparam int PC = tree_cnt(LEAVES, l - 1);

      // Valid bit travelling alongside this level's sums.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld <= 1'b0;
        end else if (en) begin
          vld <= g_lvl[l-1].vld;
        end
      end

      for (j = 0; j < LEAVES; j++) begin : g_node
        if (2*j + 1 < PC) begin : g_add
          // Pairwise sum of two nodes from the previous level.
          always_ff @(posedge clk) begin
            if (!rst_n) begin
              node[j] <= '0;
            end else if (en) begin
              node[j] <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
            end
          end
        end else if (2*j < PC) begin : g_pass
          // Odd node out: delayed so it stays aligned with its siblings.
          always_ff @(posedge clk) begin
            if (!rst_n) begin
              node[j] <= '0;
            end else if (en) begin
              node[j] <= g_lvl[l-1].node[2*j];
            end
          end
        end else begin : g_zero
          // Slot not used at this level; held at zero.
          always_ff @(posedge clk) begin
            node[j] <= '0;
          end
        end
      end
    end
  end

  assign out_valid = g_lvl[LV].vld;
  assign sum       = g_lvl[LV].node[0];

endmodule

// File: rtl/conv_filter_pipe.sv
// KxK signed fixed-point convolution: weighted sum of one window plus bias,
// rounded half-up and saturated, fully pipelined with valid/ready on both
// sides. Optional macro CONV_FILTER_RELU_EN clamps negative results to zero.
module conv_filter_pipe
  import conv_pkg::*;
#(
  parameter  int KERNEL = 3,
  parameter  int DATA_W = 16,
  parameter  int FRAC_W = 8,
  localparam int N      = KERNEL * KERNEL,
  localparam int AW     = clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                wt_we,
  input  logic [AW-1:0]       wt_addr,
  input  logic [DATA_W-1:0]   wt_data,
  input  logic                bias_we,
  input  logic [DATA_W-1:0]   bias_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sat
);

  // Pipeline: S0 capture, S1 multiply, T tree levels, final round/saturate.
  // With the bias as an extra leaf the tree needs clog2(N+1) levels.
  localparam int LEAVES = N + 1;
  localparam int T      = clog2(LEAVES);
  localparam int PW     = 2 * DATA_W;
  localparam int ACC_W  = PW + T;

  logic signed [DATA_W-1:0] weight_r [0:N-1];
  logic signed [DATA_W-1:0] bias_r;
  logic                     en_s;

  logic                     v0_r;
  logic signed [DATA_W-1:0] d0_r [0:N-1];
  logic signed [DATA_W-1:0] w0_r [0:N-1];
  logic signed [DATA_W-1:0] b0_r;

  logic signed [PW-1:0]     prod_s [0:N-1];
  logic signed [ACC_W-1:0]  bias_leaf_s;

  logic                     v1_r;
  logic [LEAVES*ACC_W-1:0]  leaf1_r;

  logic                     tree_valid_s;
  logic signed [ACC_W-1:0]  tree_sum_s;

  logic                     sat_s;
  logic [MAX_W-DATA_W-1:0]  rs_hi_unused_s;
  logic [DATA_W-1:0]        res_s;

  logic                     out_valid_r;
  logic [DATA_W-1:0]        out_data_r;
  logic                     out_sat_r;

  // The whole pipe moves only when the output slot is empty or draining.
  assign en_s      = !out_valid_r || out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;

  // Coefficient bank; out-of-range tap addresses match no entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        weight_r[i] <= '0;
      end
      bias_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wt_we && (wt_addr == AW'(i))) begin
          weight_r[i] <= wt_data;
        end
      end
      if (bias_we) begin
        bias_r <= bias_data;
      end
    end
  end

  // S0: capture the window with a coefficient snapshot, so later writes
  // never reach windows already accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        d0_r[i] <= '0;
        w0_r[i] <= '0;
      end
      b0_r <= '0;
    end else if (en_s) begin
      v0_r <= in_valid;
      for (int i = 0; i < N; i++) begin
        d0_r[i] <= in_data[i*DATA_W +: DATA_W];
        w0_r[i] <= weight_r[i];
      end
      b0_r <= bias_r;
    end
  end

  // Full-precision products and the bias aligned to the product format.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod_s[i] = {{DATA_W{d0_r[i][DATA_W-1]}}, d0_r[i]} *
                  {{DATA_W{w0_r[i][DATA_W-1]}}, w0_r[i]};
    end
    bias_leaf_s = {{(ACC_W-DATA_W){b0_r[DATA_W-1]}}, b0_r} <<< FRAC_W;
  end

  // S1: register the sign-extended leaves for the adder tree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      leaf1_r <= '0;
    end else if (en_s) begin
      v1_r <= v0_r;
      for (int i = 0; i < N; i++) begin
        leaf1_r[i*ACC_W +: ACC_W] <= {{(ACC_W-PW){prod_s[i][PW-1]}}, prod_s[i]};
      end
      leaf1_r[N*ACC_W +: ACC_W] <= bias_leaf_s;
    end
  end

  conv_adder_tree #(
    .LEAVES (LEAVES),
    .W      (ACC_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_s),
    .in_valid  (v1_r),
    .leaves    (leaf1_r),
    .out_valid (tree_valid_s),
    .sum       (tree_sum_s)
  );

  // Round, saturate and (optionally) rectify the tree result.
  always_comb begin
    {sat_s, rs_hi_unused_s, res_s} = round_sat(
        {{(MAX_W-ACC_W){tree_sum_s[ACC_W-1]}}, tree_sum_s}, DATA_W, FRAC_W);
`ifdef CONV_FILTER_RELU_EN
    if (res_s[DATA_W-1]) begin
      res_s = '0;
    end else begin
      res_s = res_s;
    end
`endif
  end

  // Final stage: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= tree_valid_s;
      out_data_r  <= res_s;
      out_sat_r   <= sat_s;
    end
  end

endmodule

// File: tb/tb_conv_filter_pipe.sv
// Directed self-checking bench for conv_filter_pipe (KERNEL=3, Q7.8).
module tb_conv_filter_pipe;

  localparam int N  = 9;
  localparam int AW = 4;
  localparam int DW = 16;

`ifdef CONV_FILTER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic            wt_we;
  logic [AW-1:0]   wt_addr;
  logic [DW-1:0]   wt_data;
  logic            bias_we;
  logic [DW-1:0]   bias_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_filter_pipe #(.KERNEL(3), .DATA_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .bias_we(bias_we), .bias_data(bias_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
    logic [N*DW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = v;
    return f;
  endfunction

  task automatic write_wt(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); wt_we = 1'b1; wt_addr = a; wt_data = d;
    @(negedge clk); wt_we = 1'b0;
  endtask

  task automatic write_bias(input logic [DW-1:0] d);
    @(negedge clk); bias_we = 1'b1; bias_data = d;
    @(negedge clk); bias_we = 1'b0;
  endtask

  task automatic set_weights(input logic [DW-1:0] d);
    for (int i = 0; i < N; i++) write_wt(AW'(i), d);
  endtask

  // Send one window with out_ready=1; lat counts edges from the accept edge
  // (accept edge = 1) to the first cycle out_valid is seen high.
  task automatic run_window(input logic [N*DW-1:0] d, output logic [DW-1:0] q,
                            output logic s, output int lat);
    q = '0; s = 1'b0; lat = 0;
    @(negedge clk); in_valid = 1'b1; in_data = d; #1;
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); in_valid = 1'b0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      if (out_valid) begin lat = e; q = out_data; s = out_sat; end
      else @(negedge clk);
    end
  endtask

  logic [DW-1:0]   q;
  logic            s;
  int              lat;
  logic [N*DW-1:0] v;
  logic [DW-1:0]   exp_q [0:19];
  logic [DW-1:0]   res [0:1];
  logic [DW-1:0]   prev_data;
  logic            prev_stall;
  int              sent, got, extra, n, stale;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; wt_we = 1'b0; wt_addr = '0;
    wt_data = '0; bias_we = 1'b0; bias_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Ones: 9 * 1.0 + 0.5 = 9.5
    set_weights(16'h0100); write_bias(16'h0080);
    run_window(fill(16'h0100), q, s, lat);
    check("ones_data", {16'd0, q}, 32'h0980);
    check("ones_sat", {31'd0, s}, 32'd0);
    check("ones_latency", lat, 32'd7);
    @(negedge clk);
    check("ones_single", {31'd0, out_valid}, 32'd0);

    // Rounding: 0.5 * 2^-8 = 2^-9 rounds half-up to one LSB
    set_weights(16'h0000); write_wt(4'd0, 16'h0080); write_bias(16'h0000);
    v = '0; v[15:0] = 16'h0001;
    run_window(v, q, s, lat);
    check("round_data", {16'd0, q}, 32'h0001);

    // Negative: 9 * -1.0 = -9.0
    set_weights(16'hFF00);
    run_window(fill(16'h0100), q, s, lat);
    check("neg_data", {16'd0, q}, RELU ? 32'h0000 : 32'hF700);
    check("neg_sat", {31'd0, s}, 32'd0);

    // Saturation both ways
    set_weights(16'h7FFF);
    run_window(fill(16'h7FFF), q, s, lat);
    check("satp_data", {16'd0, q}, 32'h7FFF);
    check("satp_sat", {31'd0, s}, 32'd1);
    run_window(fill(16'h8000), q, s, lat);
    check("satn_data", {16'd0, q}, RELU ? 32'h0000 : 32'h8000);
    check("satn_sat", {31'd0, s}, 32'd1);

    // Tap order: weight i = (i+1).0, data i = (i+1)/16 -> sum k^2 / 16 = 0x11D0
    for (int i = 0; i < N; i++) write_wt(AW'(i), DW'((i + 1) * 256));
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'((i + 1) * 16);
    run_window(v, q, s, lat);
    check("order_data", {16'd0, q}, 32'h11D0);

    // Backpressure: output = tap 0, out_ready toggles 1,0,1,0
    set_weights(16'h0000); write_wt(4'd0, 16'h0100);
    for (int k = 0; k < 20; k++) exp_q[k] = DW'(16'h0100 + k * 16'h0011);
    sent = 0; got = 0; extra = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 300 && (sent < 20 || got < 20); c++) begin
      @(negedge clk);
      out_ready = (c % 2 == 0);
      in_valid = (sent < 20);
      v = fill(DW'(sent * 3 + 1));
      if (sent < 20) v[15:0] = exp_q[sent];
      in_data = v;
      #1;
      check("bp_in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (prev_stall) check("bp_hold", {16'd0, out_data}, {16'd0, prev_data});
      if (out_valid && out_ready) begin
        if (got < 20) check("bp_data", {16'd0, out_data}, {16'd0, exp_q[got]});
        else extra++;
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("bp_count", got, 32'd20);
    check("bp_extra", extra, 32'd0);

    // Weight timing: A accepted with the write uses 1.0, B next cycle uses 2.0
    @(negedge clk);
    v = '0; v[15:0] = 16'h0100;
    wt_we = 1'b1; wt_addr = 4'd0; wt_data = 16'h0200; in_valid = 1'b1; in_data = v;
    #1; check("wt_a_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); wt_we = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      if (out_valid) begin res[n] = out_data; n++; end
      @(negedge clk);
    end
    check("wt_count", n, 32'd2);
    check("wt_a_old", {16'd0, res[0]}, 32'h0100);
    check("wt_b_new", {16'd0, res[1]}, 32'h0200);

    // Out-of-range address ignored: only weight0 = 2.0 is non-zero
    write_wt(4'd9, 16'h7FFF);
    run_window(fill(16'h0100), q, s, lat);
    check("addr9_data", {16'd0, q}, 32'h0200);

    // Simultaneous weight and bias write: 2.0 + 1.0 + bias 1.0 = 4.0
    @(negedge clk); wt_we = 1'b1; wt_addr = 4'd1; wt_data = 16'h0100;
    bias_we = 1'b1; bias_data = 16'h0100;
    @(negedge clk); wt_we = 1'b0; bias_we = 1'b0;
    run_window(fill(16'h0100), q, s, lat);
    check("both_we_data", {16'd0, q}, 32'h0400);

    // Reset mid-stream with three windows in flight
    set_weights(16'h0100); write_bias(16'h0080);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b1; in_data = fill(DW'(16'h0100 + k));
    end
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_stale", stale, 32'd0);
    run_window(fill(16'h0100), q, s, lat);
    check("midrst_zero", {16'd0, q}, 32'h0000);
    check("midrst_latency", lat, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
